pipe_ctrl: RTL

//  Pipeline sequencer for the IF/ID stage and PC. Merges stall requests, accepts jump and interrupt redirects,
//  and drives hold_flag_o. Any hold_flag_o >= Hold_If makes the IF/ID register load INST_NOP / ZeroWord,
//  so holds act as bubbles. After each redirect it runs a timed flush, then watches for stuck stalls.

---
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
//   Bundles the stall, redirect and hold-control signals exchanged between the
//   pipeline sequencer (slave side) and the surrounding core (master side).
//   Signal suffixes are written from the sequencer's point of view.
//
//   hold_ex_i        EX busy, needs Hold_Id
//   hold_id_i        ID load-use hazard, needs Hold_If
//   hold_bus_i       fetch bus not ready, needs Hold_Pc
//   jump_req_i       EX branch/jump taken this cycle
//   jump_addr_i      jump target
//   int_req_i        interrupt pending, held until int_ack_o
//   int_addr_i       trap vector
//   hold_flag_o      0 none, 1 PC, 2 IF, 3 ID
//   jump_flag_o      registered PC redirect strobe
//   jump_addr_o      registered PC redirect target
//   int_ack_o        one-cycle interrupt acceptance pulse
//   stall_timeout_o  stuck-stall watchdog flag
// ---------------------------------------------------------------------------
interface pipe_ctrl_if;
  logic        hold_ex_i;
  logic        hold_id_i;
  logic        hold_bus_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        int_req_i;
  logic [31:0] int_addr_i;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        int_ack_o;
  logic        stall_timeout_o;

  modport master (
    output hold_ex_i, hold_id_i, hold_bus_i,
    output jump_req_i, jump_addr_i, int_req_i, int_addr_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, stall_timeout_o
  );

  modport slave (
    input  hold_ex_i, hold_id_i, hold_bus_i,
    input  jump_req_i, jump_addr_i, int_req_i, int_addr_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, int_ack_o, stall_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline sequencer for the IF/ID stage and the PC. Merges stall requests
//   into a single hold level, accepts jump and interrupt redirects, bubbles
//   IF/ID for FLUSH_CYCLES after each redirect, and flags stalls that last
//   TIMEOUT consecutive cycles.
//
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   pipe_ctrl_if.slave: stall inputs, redirect requests, hold level,
//         redirect strobe/target, interrupt ack, watchdog flag
//
//   Parameters
//   FLUSH_CYCLES  bubble cycles after the redirect cycle (0..15)
//   TIMEOUT       stall cycles before stall_timeout_o asserts (1..65535)
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam int unsigned       SW      = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]     STALL_MAX = SW'(TIMEOUT);
  localparam logic [3:0]        FLUSH_LD  = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          jflag_q, jflag_d;
  logic          ack_q, ack_d;
  logic [3:0]    flush_q, flush_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          tmo_q, tmo_d;
  logic [2:0]    hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      addr_q  <= '0;
      jflag_q <= 1'b0;
      ack_q   <= 1'b0;
      flush_q <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      jflag_q <= jflag_d;
      ack_q   <= ack_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    jflag_d = 1'b0;
    ack_d   = 1'b0;
    flush_d = flush_q;
    stall_d = '0;
    hold    = HOLD_NONE;

    unique case (state_q)
      RUN: begin
        // Redirects wait while EX is busy so a multi-cycle op is never squashed.
        if (!bus.hold_ex_i && (bus.int_req_i || bus.jump_req_i)) begin
          state_d = REDIR;
          hold    = HOLD_ID;
          jflag_d = 1'b1;
          ack_d   = bus.int_req_i;
          addr_d  = bus.int_req_i ? bus.int_addr_i : bus.jump_addr_i;
        end else begin
          if (bus.hold_ex_i)       hold = HOLD_ID;
          else if (bus.hold_id_i)  hold = HOLD_IF;
          else if (bus.hold_bus_i) hold = HOLD_PC;
          else                     hold = HOLD_NONE;
          if (hold != HOLD_NONE)
            stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
        end
      end
      REDIR: begin
        hold    = HOLD_ID;
        flush_d = FLUSH_LD;
        state_d = (FLUSH_LD != 4'd0) ? FLUSH : RUN;
      end
      FLUSH: begin
        hold    = bus.hold_ex_i ? HOLD_ID : HOLD_IF;
        flush_d = flush_q - 4'd1;
        // <= 1 rather than == 1 so a corrupted zero count cannot wrap for 16 cycles.
        if (flush_q <= 4'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    tmo_d = (stall_d == STALL_MAX);
  end

  // Hold level is combinational; force it to Hold_None while reset is asserted.
  assign bus.hold_flag_o     = rst ? hold : HOLD_NONE;
  assign bus.jump_flag_o     = jflag_q;
  assign bus.jump_addr_o     = addr_q;
  assign bus.int_ack_o       = ack_q;
  assign bus.stall_timeout_o = tmo_q;

endmodule
